xbar_bank_dispatch: RTL and testbench
=====================================

# xbar_bank_dispatch

Parametrised request dispatcher between the crossbar channels and the cache bank array. It accepts up to NUM_CH channel requests per cycle, steers each to the bank selected by its line-address bits, and arbitrates round-robin among channels targeting the same bank. Each bank has a one-entry output register with a valid/allowIn handshake, so every bank can accept one request per cycle under backpressure. It replaces the fixed four-bank wrapper: bank and channel counts are parameters, and multi-channel arbitration is new.

## Interface
- NUM_CH, 4, number of requesting channels, ≥1
- NUM_BANKS, 4, number of banks, power of two, ≥1
- WBID_W, 8, write-buffer id width
- Derived: CH_W = max(1, clog2(NUM_CH)); BSEL_W = clog2(NUM_BANKS)
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- ch_valid_i  in  NUM_CH  per-channel request valid
- ch_allowIn_o  out  NUM_CH  per-channel accept
- ch_opcode_i  in  2*NUM_CH  opcode, channel c at [2c+1:2c]
- ch_addr_i  in  28*NUM_CH  line address [31:4], channel c at [28c+27:28c]
- ch_wbuffer_id_i  in  WBID_W*NUM_CH  write-buffer id
- bank_valid_o  out  NUM_BANKS  per-bank request valid
- bank_allowIn_i  in  NUM_BANKS  per-bank ready
- bank_ch_id_o  out  CH_W*NUM_BANKS  index of the originating channel
- bank_opcode_o  out  2*NUM_BANKS  opcode
- bank_addr_o  out  28*NUM_BANKS  line address [31:4]
- bank_wbuffer_id_o  out  WBID_W*NUM_BANKS  write-buffer id

## Operation
- **Bank select:** target bank of channel c = addr[4+BSEL_W-1:4]. With NUM_BANKS=1, all requests target bank 0.
- **Per-bank slot:** register holding valid_q plus payload {ch_id, opcode, addr, wbuffer_id}.
- **Slot capacity:** slot b can load this cycle iff !valid_q[b] || bank_allowIn_i[b].
- **Requesters:** req[b][c] = ch_valid_i[c] && target(c)==b.
- **Arbiter:** fixed-order scan starting at rr_ptr[b], wrapping modulo NUM_CH. The first requesting channel wins. Each arbiter is CH_W bits wide.
- **Grant:** grant[b][c] is raised only when slot b can load.
- **Channel accept:** ch_allowIn_o[c] = OR over b of grant[b][c]. It is combinational from ch_valid_i, ch_addr_i and bank_allowIn_i, and never depends on its own registered output.
- **On grant to channel g at bank b:**
  - valid_q[b] ← 1 and payload ← channel g fields, with ch_id = g.
  - rr_ptr[b] ← (g+1) mod NUM_CH.
- **Drain without load:** valid_q[b] ← 0; payload holds its last value.
- **No grant:** rr_ptr is unchanged.
- **Stall:** slot holds with valid_q=1 while !bank_allowIn_i, and payload is stable until accepted.
- **Channel rule:** while ch_valid_i=1 and not accepted, the channel must hold its payload stable. The dispatcher does not check this.
- **Independence:** different banks grant independently in the same cycle. Multiple channels can be accepted in one cycle if they target distinct banks.

## Timing
- **Reset** (asynchronous assert; release is synchronous to clk_i by the reset tree):
  - valid_q=0 and all bank_* payload outputs =0.
  - rr_ptr=0 for every bank.
  - ch_allowIn_o is forced 0 while rst_i=1.
- **Reset mid-operation:** in-flight slot contents are discarded without handshake. Channels must reissue.
- **Latency:** request accepted at edge N appears on bank_valid_o from edge N, i.e. visible in cycle N+1.
- **Throughput:** one request per bank per cycle with bank_allowIn_i held 1. No bubble on simultaneous drain and load.
- **Full slot with bank not ready:** all requesters of that bank see ch_allowIn_o=0. rr_ptr is frozen.
- **Wrap-around:** rr_ptr from NUM_CH-1 wraps to 0.
- **Single requester:** granted regardless of rr_ptr.
- **Outputs:** all bank_* outputs are registered, with no combinational path from ch_* inputs to bank_* outputs.

## Test plan
- **Reset:** assert rst_i mid-traffic with a slot holding data -> bank_valid_o=0 and ch_allowIn_o=0 immediately, without waiting for a clock edge. After release, the first grant at each bank goes to the lowest-indexed requester.
- **Distinct banks:** 4 channels with addr[5:4]=c, all bank_allowIn_i=1 -> all four ch_allowIn_o=1 in the same cycle. Next cycle, bank_valid_o=4'b1111 and bank_ch_id_o[b]=b.
- **Round-robin:** all 4 channels continuously targeting bank 2, bank ready -> grants in order 0,1,2,3,0. Each channel is granted once per 4 cycles.
- **Backpressure:** channel 1 sends opcode=2, addr=0x0000_0A0 (bank 2), wbuffer_id=0x5A, then bank_allowIn_i[2]=0 for 3 cycles.
  - Payload stays stable with bank_valid_o[2]=1.
  - A second request to bank 2 sees ch_allowIn_o=0 for those 3 cycles.
  - It is accepted in the cycle allowIn rises, with no idle cycle on bank 2.
- **Parametrisation:** NUM_BANKS=1, NUM_CH=3 -> all requests go to bank 0 with round-robin 0,1,2,0. NUM_BANKS=8 -> addr[6:4] selects the bank.
- **Mixed contention:** channels 0 and 2 target bank 1 while channel 3 targets bank 0 -> channel 3 plus one of {0,2} are accepted in the same cycle. The loser is accepted the next cycle.

Source files
------------

// File: rtl/xbar_bank_dispatch.sv
// Dispatches crossbar channel requests to cache banks selected by line-address bits,
// with round-robin arbitration per bank and a one-entry registered output slot per bank.
module xbar_bank_dispatch #(
   parameter int NUM_CH    = 4,
   parameter int NUM_BANKS = 4,
   parameter int WBID_W    = 8,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NUM_CH-1:0]            ch_valid_i,
   output logic [NUM_CH-1:0]            ch_allowIn_o,
   input  logic [2*NUM_CH-1:0]          ch_opcode_i,
   input  logic [28*NUM_CH-1:0]         ch_addr_i,
   input  logic [WBID_W*NUM_CH-1:0]     ch_wbuffer_id_i,
   output logic [NUM_BANKS-1:0]         bank_valid_o,
   input  logic [NUM_BANKS-1:0]         bank_allowIn_i,
   output logic [CH_W*NUM_BANKS-1:0]    bank_ch_id_o,
   output logic [2*NUM_BANKS-1:0]       bank_opcode_o,
   output logic [28*NUM_BANKS-1:0]      bank_addr_o,
   output logic [WBID_W*NUM_BANKS-1:0]  bank_wbuffer_id_o
);

   // A single bank still needs a 1-bit select; it is forced to zero below.
   localparam int SEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

   logic [SEL_W-1:0]     w_target     [NUM_CH];
   logic [NUM_CH-1:0]    w_req        [NUM_BANKS];
   logic [NUM_CH-1:0]    w_grant      [NUM_BANKS];
   logic [NUM_BANKS-1:0] w_can_load;
   logic [NUM_BANKS-1:0] w_win_vld;
   logic [CH_W-1:0]      w_win_idx    [NUM_BANKS];
   logic [CH_W-1:0]      w_next_ptr   [NUM_BANKS];
   logic [1:0]           w_sel_opcode [NUM_BANKS];
   logic [27:0]          w_sel_addr   [NUM_BANKS];
   logic [WBID_W-1:0]    w_sel_wbid   [NUM_BANKS];

   logic [NUM_BANKS-1:0] r_valid;
   logic [CH_W-1:0]      r_ch_id      [NUM_BANKS];
   logic [1:0]           r_opcode     [NUM_BANKS];
   logic [27:0]          r_addr       [NUM_BANKS];
   logic [WBID_W-1:0]    r_wbid       [NUM_BANKS];
   logic [CH_W-1:0]      r_rr_ptr     [NUM_BANKS];

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         w_target[c] = '0;
         if (NUM_BANKS > 1) w_target[c] = ch_addr_i[28*c+4 +: SEL_W];
      end
   end

   // Round-robin: lowest requester at or above rr_ptr wins, else lowest below it.
   always_comb begin
      logic            w_hi_found;
      logic            w_lo_found;
      logic [CH_W-1:0] w_hi_idx;
      logic [CH_W-1:0] w_lo_idx;
      // NOTE: every comb output gets a default first so no path can infer a latch.
      w_hi_found = 1'b0;
      w_lo_found = 1'b0;
      w_hi_idx   = '0;
      w_lo_idx   = '0;
      w_can_load = '0;
      w_win_vld  = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         w_hi_found      = 1'b0;
         w_lo_found      = 1'b0;
         w_hi_idx        = '0;
         w_lo_idx        = '0;
         w_req[b]        = '0;
         w_grant[b]      = '0;
         w_sel_opcode[b] = '0;
         w_sel_addr[b]   = '0;
         w_sel_wbid[b]   = '0;
         for (int c = NUM_CH - 1; c >= 0; c--) begin
            w_req[b][c] = ch_valid_i[c] && (w_target[c] == SEL_W'(b));
            if (w_req[b][c]) begin
               if (CH_W'(c) >= r_rr_ptr[b]) begin
                  w_hi_found = 1'b1;
                  w_hi_idx   = CH_W'(c);
               end else begin
                  w_lo_found = 1'b1;
                  w_lo_idx   = CH_W'(c);
               end
            end
         end
         w_can_load[b] = !r_valid[b] || bank_allowIn_i[b];
         w_win_vld[b]  = (w_hi_found || w_lo_found) && w_can_load[b];
         w_win_idx[b]  = w_hi_found ? w_hi_idx : w_lo_idx;
         w_next_ptr[b] = (w_win_idx[b] == CH_W'(NUM_CH - 1)) ? '0 : w_win_idx[b] + CH_W'(1);
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_win_vld[b] && (w_win_idx[b] == CH_W'(c))) begin
               w_grant[b][c]   = 1'b1;
               w_sel_opcode[b] = ch_opcode_i[2*c +: 2];
               w_sel_addr[b]   = ch_addr_i[28*c +: 28];
               w_sel_wbid[b]   = ch_wbuffer_id_i[WBID_W*c +: WBID_W];
            end
         end
      end
   end

   always_comb begin
      ch_allowIn_o = '0;
      for (int b = 0; b < NUM_BANKS; b++) ch_allowIn_o = ch_allowIn_o | w_grant[b];
      if (rst_i) ch_allowIn_o = '0;
   end

   // NOTE: payload registers are reset too, so bank outputs read zero straight out of reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid <= '0;
         for (int b = 0; b < NUM_BANKS; b++) begin
            r_ch_id[b]  <= '0;
            r_opcode[b] <= '0;
            r_addr[b]   <= '0;
            r_wbid[b]   <= '0;
            r_rr_ptr[b] <= '0;
         end
      end else begin
         // NOTE: non-blocking so every bank samples pre-edge state regardless of loop order.
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_win_vld[b]) begin
               r_valid[b]  <= 1'b1;
               r_ch_id[b]  <= w_win_idx[b];
               r_opcode[b] <= w_sel_opcode[b];
               r_addr[b]   <= w_sel_addr[b];
               r_wbid[b]   <= w_sel_wbid[b];
               r_rr_ptr[b] <= w_next_ptr[b];
            end else if (bank_allowIn_i[b]) begin
               r_valid[b]  <= 1'b0;
            end
         end
      end
   end

   assign bank_valid_o = r_valid;

   always_comb begin
      bank_ch_id_o      = '0;
      bank_opcode_o     = '0;
      bank_addr_o       = '0;
      bank_wbuffer_id_o = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_ch_id_o[CH_W*b +: CH_W]          = r_ch_id[b];
         bank_opcode_o[2*b +: 2]               = r_opcode[b];
         bank_addr_o[28*b +: 28]               = r_addr[b];
         bank_wbuffer_id_o[WBID_W*b +: WBID_W] = r_wbid[b];
      end
   end

endmodule

// File: tb/tb_xbar_bank_dispatch.sv
// Directed bench for xbar_bank_dispatch: default 4x4 instance plus 3ch/1-bank and 2ch/8-bank variants.
module tb_xbar_bank_dispatch;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // default configuration: 4 channels, 4 banks
   logic [3:0]   ch_valid, ch_allowIn;
   logic [7:0]   ch_opcode;
   logic [111:0] ch_addr;
   logic [31:0]  ch_wbid;
   logic [3:0]   bank_valid, bank_allowIn;
   logic [7:0]   bank_ch_id, bank_opcode;
   logic [111:0] bank_addr;
   logic [31:0]  bank_wbid;

   // 3 channels, 1 bank
   logic [2:0]  p1_valid, p1_allowIn;
   logic [5:0]  p1_opcode;
   logic [83:0] p1_addr;
   logic [23:0] p1_wbid;
   logic [0:0]  p1_bank_valid, p1_bank_allowIn;
   logic [1:0]  p1_bank_ch_id, p1_bank_opcode;
   logic [27:0] p1_bank_addr;
   logic [7:0]  p1_bank_wbid;

   // 2 channels, 8 banks
   logic [1:0]   p8_valid, p8_allowIn;
   logic [3:0]   p8_opcode;
   logic [55:0]  p8_addr;
   logic [15:0]  p8_wbid;
   logic [7:0]   p8_bank_valid, p8_bank_allowIn, p8_bank_ch_id;
   logic [15:0]  p8_bank_opcode;
   logic [223:0] p8_bank_addr;
   logic [63:0]  p8_bank_wbid;

   xbar_bank_dispatch #(.NUM_CH(4), .NUM_BANKS(4), .WBID_W(8)) dut (
      .clk_i(clk), .rst_i(rst),
      .ch_valid_i(ch_valid), .ch_allowIn_o(ch_allowIn), .ch_opcode_i(ch_opcode),
      .ch_addr_i(ch_addr), .ch_wbuffer_id_i(ch_wbid),
      .bank_valid_o(bank_valid), .bank_allowIn_i(bank_allowIn), .bank_ch_id_o(bank_ch_id),
      .bank_opcode_o(bank_opcode), .bank_addr_o(bank_addr), .bank_wbuffer_id_o(bank_wbid)
   );

   xbar_bank_dispatch #(.NUM_CH(3), .NUM_BANKS(1), .WBID_W(8)) dut_b1 (
      .clk_i(clk), .rst_i(rst),
      .ch_valid_i(p1_valid), .ch_allowIn_o(p1_allowIn), .ch_opcode_i(p1_opcode),
      .ch_addr_i(p1_addr), .ch_wbuffer_id_i(p1_wbid),
      .bank_valid_o(p1_bank_valid), .bank_allowIn_i(p1_bank_allowIn), .bank_ch_id_o(p1_bank_ch_id),
      .bank_opcode_o(p1_bank_opcode), .bank_addr_o(p1_bank_addr), .bank_wbuffer_id_o(p1_bank_wbid)
   );

   xbar_bank_dispatch #(.NUM_CH(2), .NUM_BANKS(8), .WBID_W(8)) dut_b8 (
      .clk_i(clk), .rst_i(rst),
      .ch_valid_i(p8_valid), .ch_allowIn_o(p8_allowIn), .ch_opcode_i(p8_opcode),
      .ch_addr_i(p8_addr), .ch_wbuffer_id_i(p8_wbid),
      .bank_valid_o(p8_bank_valid), .bank_allowIn_i(p8_bank_allowIn), .bank_ch_id_o(p8_bank_ch_id),
      .bank_opcode_o(p8_bank_opcode), .bank_addr_o(p8_bank_addr), .bank_wbuffer_id_o(p8_bank_wbid)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int c, input logic v, input logic [1:0] op,
                         input logic [27:0] a, input logic [7:0] id);
      ch_valid[c]         = v;
      ch_opcode[2*c +: 2] = op;
      ch_addr[28*c +: 28] = a;
      ch_wbid[8*c +: 8]   = id;
   endtask

   task automatic clear_all();
      ch_valid = '0; ch_opcode = '0; ch_addr = '0; ch_wbid = '0; bank_allowIn = '1;
      p1_valid = '0; p1_opcode = '0; p1_addr = '0; p1_wbid = '0; p1_bank_allowIn = '1;
      p8_valid = '0; p8_opcode = '0; p8_addr = '0; p8_wbid = '0; p8_bank_allowIn = '1;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 4; c++) set_ch(c, 1'b1, 2'(c), 28'(c) << 4, 8'(c));
      #1;
      n_total++;
      if (ch_allowIn !== 4'h0) $display("FAIL reset_allow: got %h expected %h", ch_allowIn, 4'h0);
      else n_pass++;
      n_total++;
      if (bank_valid !== 4'h0) $display("FAIL reset_valid: got %h expected %h", bank_valid, 4'h0);
      else n_pass++;
      n_total++;
      if (bank_addr !== 112'h0 || bank_ch_id !== 8'h0 || bank_wbid !== 32'h0)
         $display("FAIL reset_payload: got %h/%h/%h expected zero", bank_addr, bank_ch_id, bank_wbid);
      else n_pass++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_all();
      tick();
   endtask

   task automatic test_round_robin();
      for (int c = 0; c < 4; c++) set_ch(c, 1'b1, 2'd1, 28'h0000_020, 8'h20 + 8'(c));
      for (int i = 0; i < 5; i++) begin
         int e;
         e = i % 4;
         #1;
         n_total++;
         if (ch_allowIn !== 4'(1 << e)) $display("FAIL rr_allow[%0d]: got %b expected %b", i, ch_allowIn, 4'(1 << e));
         else n_pass++;
         tick();
         n_total++;
         if (bank_valid !== 4'b0100 || bank_ch_id[5:4] !== 2'(e) || bank_wbid[23:16] !== 8'h20 + 8'(e))
            $display("FAIL rr_bank[%0d]: got valid=%b id=%0d wbid=%h expected valid=0100 id=%0d wbid=%h",
                     i, bank_valid, bank_ch_id[5:4], bank_wbid[23:16], e, 8'h20 + 8'(e));
         else n_pass++;
      end
      clear_all();
      tick();
   endtask

   task automatic test_distinct_banks();
      for (int c = 0; c < 4; c++) set_ch(c, 1'b1, 2'(c), 28'(c) << 4, 8'h10 + 8'(c));
      #1;
      n_total++;
      if (ch_allowIn !== 4'hF) $display("FAIL distinct_allow: got %b expected %b", ch_allowIn, 4'hF);
      else n_pass++;
      tick();
      n_total++;
      if (bank_valid !== 4'hF) $display("FAIL distinct_valid: got %b expected %b", bank_valid, 4'hF);
      else n_pass++;
      n_total++;
      if (bank_ch_id !== 8'hE4) $display("FAIL distinct_ch_id: got %h expected %h", bank_ch_id, 8'hE4);
      else n_pass++;
      n_total++;
      if (bank_opcode !== 8'hE4) $display("FAIL distinct_opcode: got %h expected %h", bank_opcode, 8'hE4);
      else n_pass++;
      n_total++;
      if (bank_addr !== {28'h30, 28'h20, 28'h10, 28'h0})
         $display("FAIL distinct_addr: got %h expected %h", bank_addr, {28'h30, 28'h20, 28'h10, 28'h0});
      else n_pass++;
      n_total++;
      if (bank_wbid !== 32'h1312_1110) $display("FAIL distinct_wbid: got %h expected %h", bank_wbid, 32'h1312_1110);
      else n_pass++;
      clear_all();
      tick();
      n_total++;
      if (bank_valid !== 4'h0) $display("FAIL drain_valid: got %b expected %b", bank_valid, 4'h0);
      else n_pass++;
      n_total++;
      if (bank_wbid !== 32'h1312_1110) $display("FAIL drain_hold: got %h expected %h", bank_wbid, 32'h1312_1110);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      set_ch(1, 1'b1, 2'd2, 28'h0000_0A0, 8'h5A);
      #1;
      n_total++;
      if (ch_allowIn !== 4'b0010) $display("FAIL bp_first_allow: got %b expected %b", ch_allowIn, 4'b0010);
      else n_pass++;
      tick();
      n_total++;
      if (bank_valid !== 4'b0100 || bank_opcode[5:4] !== 2'd2 || bank_addr[56 +: 28] !== 28'h0A0
          || bank_wbid[23:16] !== 8'h5A || bank_ch_id[5:4] !== 2'd1)
         $display("FAIL bp_load: got valid=%b op=%0d addr=%h wbid=%h id=%0d expected 0100/2/0a0/5a/1",
                  bank_valid, bank_opcode[5:4], bank_addr[56 +: 28], bank_wbid[23:16], bank_ch_id[5:4]);
      else n_pass++;
      set_ch(1, 1'b0, 2'd0, 28'h0, 8'h0);
      set_ch(3, 1'b1, 2'd1, 28'h0000_1E0, 8'hC3);
      bank_allowIn = 4'b1011;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_total++;
         if (ch_allowIn !== 4'b0000) $display("FAIL bp_stall_allow[%0d]: got %b expected %b", i, ch_allowIn, 4'b0000);
         else n_pass++;
         tick();
         n_total++;
         if (bank_valid[2] !== 1'b1 || bank_addr[56 +: 28] !== 28'h0A0 || bank_wbid[23:16] !== 8'h5A)
            $display("FAIL bp_stall_hold[%0d]: got valid=%b addr=%h wbid=%h expected 1/0a0/5a",
                     i, bank_valid[2], bank_addr[56 +: 28], bank_wbid[23:16]);
         else n_pass++;
      end
      bank_allowIn = 4'hF;
      #1;
      n_total++;
      if (ch_allowIn !== 4'b1000) $display("FAIL bp_release_allow: got %b expected %b", ch_allowIn, 4'b1000);
      else n_pass++;
      tick();
      n_total++;
      if (bank_valid !== 4'b0100 || bank_ch_id[5:4] !== 2'd3 || bank_addr[56 +: 28] !== 28'h1E0
          || bank_wbid[23:16] !== 8'hC3)
         $display("FAIL bp_second_load: got valid=%b id=%0d addr=%h wbid=%h expected 0100/3/1e0/c3",
                  bank_valid, bank_ch_id[5:4], bank_addr[56 +: 28], bank_wbid[23:16]);
      else n_pass++;
      clear_all();
      tick();
   endtask

   // Pointers entering here: bank0=1 (ch0 last), bank1=2 (ch1 last).
   task automatic test_mixed();
      set_ch(0, 1'b1, 2'd0, 28'h0000_010, 8'hA0);
      set_ch(2, 1'b1, 2'd2, 28'h0000_110, 8'hA2);
      set_ch(3, 1'b1, 2'd3, 28'h0000_000, 8'hA3);
      #1;
      n_total++;
      if (ch_allowIn !== 4'b1100) $display("FAIL mixed_allow: got %b expected %b", ch_allowIn, 4'b1100);
      else n_pass++;
      tick();
      n_total++;
      if (bank_valid !== 4'b0011 || bank_ch_id[1:0] !== 2'd3 || bank_ch_id[3:2] !== 2'd2)
         $display("FAIL mixed_first: got valid=%b id0=%0d id1=%0d expected 0011/3/2",
                  bank_valid, bank_ch_id[1:0], bank_ch_id[3:2]);
      else n_pass++;
      set_ch(2, 1'b0, 2'd0, 28'h0, 8'h0);
      set_ch(3, 1'b0, 2'd0, 28'h0, 8'h0);
      #1;
      n_total++;
      if (ch_allowIn !== 4'b0001) $display("FAIL mixed_loser_allow: got %b expected %b", ch_allowIn, 4'b0001);
      else n_pass++;
      tick();
      n_total++;
      if (bank_valid !== 4'b0010 || bank_ch_id[3:2] !== 2'd0 || bank_wbid[15:8] !== 8'hA0)
         $display("FAIL mixed_loser: got valid=%b id1=%0d wbid=%h expected 0010/0/a0",
                  bank_valid, bank_ch_id[3:2], bank_wbid[15:8]);
      else n_pass++;
      clear_all();
      tick();
   endtask

   // Bank1 pointer is 1 before reset; after reset ch0 must beat ch2.
   task automatic test_reset_mid();
      set_ch(1, 1'b1, 2'd1, 28'h0000_030, 8'h77);
      tick();
      set_ch(1, 1'b0, 2'd0, 28'h0, 8'h0);
      set_ch(0, 1'b1, 2'd0, 28'h0000_000, 8'h01);
      bank_allowIn = 4'b0111;
      #1;
      n_total++;
      if (bank_valid !== 4'b1000) $display("FAIL rstmid_pre: got %b expected %b", bank_valid, 4'b1000);
      else n_pass++;
      rst = 1'b1;
      #1;
      n_total++;
      if (bank_valid !== 4'h0) $display("FAIL rstmid_valid: got %b expected %b", bank_valid, 4'h0);
      else n_pass++;
      n_total++;
      if (ch_allowIn !== 4'h0) $display("FAIL rstmid_allow: got %b expected %b", ch_allowIn, 4'h0);
      else n_pass++;
      n_total++;
      if (bank_addr !== 112'h0 || bank_wbid !== 32'h0)
         $display("FAIL rstmid_payload: got %h/%h expected zero", bank_addr, bank_wbid);
      else n_pass++;
      clear_all();
      set_ch(0, 1'b1, 2'd0, 28'h0000_010, 8'hB0);
      set_ch(2, 1'b1, 2'd2, 28'h0000_050, 8'hB2);
      tick();
      rst = 1'b0;
      #1;
      n_total++;
      if (ch_allowIn !== 4'b0001) $display("FAIL rstmid_first_grant: got %b expected %b", ch_allowIn, 4'b0001);
      else n_pass++;
      tick();
      n_total++;
      if (bank_valid !== 4'b0010 || bank_ch_id[3:2] !== 2'd0 || bank_wbid[15:8] !== 8'hB0)
         $display("FAIL rstmid_load: got valid=%b id1=%0d wbid=%h expected 0010/0/b0",
                  bank_valid, bank_ch_id[3:2], bank_wbid[15:8]);
      else n_pass++;
      clear_all();
      tick();
   endtask

   task automatic test_param_one_bank();
      p1_valid = 3'b111;
      p1_addr  = {28'h030, 28'h010, 28'h000};
      p1_wbid  = {8'hE2, 8'hE1, 8'hE0};
      p1_opcode = 6'b10_01_00;
      for (int i = 0; i < 4; i++) begin
         int e;
         e = i % 3;
         #1;
         n_total++;
         if (p1_allowIn !== 3'(1 << e)) $display("FAIL p1_allow[%0d]: got %b expected %b", i, p1_allowIn, 3'(1 << e));
         else n_pass++;
         tick();
         n_total++;
         if (p1_bank_valid !== 1'b1 || p1_bank_ch_id !== 2'(e) || p1_bank_wbid !== 8'hE0 + 8'(e))
            $display("FAIL p1_bank[%0d]: got valid=%b id=%0d wbid=%h expected 1/%0d/%h",
                     i, p1_bank_valid, p1_bank_ch_id, p1_bank_wbid, e, 8'hE0 + 8'(e));
         else n_pass++;
      end
      clear_all();
      tick();
   endtask

   task automatic test_param_eight_banks();
      p8_valid = 2'b11;
      p8_addr  = {28'h070, 28'h050};
      p8_wbid  = {8'h77, 8'h55};
      p8_opcode = 4'b11_01;
      #1;
      n_total++;
      if (p8_allowIn !== 2'b11) $display("FAIL p8_allow: got %b expected %b", p8_allowIn, 2'b11);
      else n_pass++;
      tick();
      n_total++;
      if (p8_bank_valid !== 8'hA0) $display("FAIL p8_valid: got %h expected %h", p8_bank_valid, 8'hA0);
      else n_pass++;
      n_total++;
      if (p8_bank_ch_id !== 8'h80) $display("FAIL p8_ch_id: got %h expected %h", p8_bank_ch_id, 8'h80);
      else n_pass++;
      n_total++;
      if (p8_bank_addr[140 +: 28] !== 28'h050 || p8_bank_wbid[56 +: 8] !== 8'h77)
         $display("FAIL p8_payload: got addr5=%h wbid7=%h expected 050/77",
                  p8_bank_addr[140 +: 28], p8_bank_wbid[56 +: 8]);
      else n_pass++;
      clear_all();
      tick();
   endtask

   initial begin
      rst = 1'b1;
      clear_all();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_round_robin();
      test_distinct_banks();
      test_backpressure();
      test_mixed();
      test_reset_mid();
      test_param_one_bank();
      test_param_eight_banks();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
